// File: rtl/hazard_ctrl_if.sv
// Hazard unit bundle: ID/EX/MEM/WB register tags in, pipeline controls out.
// The master side drives pipeline state; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic        UsesRs_ID;
    logic        UsesRt_ID;
    logic [4:0]  Rd_EX;
    logic        RegWr_EX;
    logic        MemRd_EX;
    logic [4:0]  Rd_MEM;
    logic        RegWr_MEM;
    logic [4:0]  Rd_WB;
    logic        RegWr_WB;
    logic        taken_ID;
    logic        halt_req;
    logic        stall;
    logic        disable_IR;
    logic        kill;
    logic        disable_PC;
    logic [1:0]  FwdA;
    logic [1:0]  FwdB;
    logic        halt_ack;
    logic [15:0] stall_cnt;
    logic [15:0] kill_cnt;

    modport master (
        output Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID,
        output Rd_EX, RegWr_EX, MemRd_EX,
        output Rd_MEM, RegWr_MEM, Rd_WB, RegWr_WB,
        output taken_ID, halt_req,
        input  stall, disable_IR, kill, disable_PC,
        input  FwdA, FwdB, halt_ack, stall_cnt, kill_cnt
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID,
        input  Rd_EX, RegWr_EX, MemRd_EX,
        input  Rd_MEM, RegWr_MEM, Rd_WB, RegWr_WB,
        input  taken_ID, halt_req,
        output stall, disable_IR, kill, disable_PC,
        output FwdA, FwdB, halt_ack, stall_cnt, kill_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, branch kill, halt drain.
// Define HAZ_PERF_EN to build the saturating stall/kill performance counters.
module hazard_ctrl (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       halt_ack_q, halt_ack_d;
    logic       load_use;
    logic       stall, disable_IR, kill, disable_PC;
    logic [1:0] fwd_a, fwd_b;

    // Nearest producing stage wins; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (hif.RegWr_EX && hif.Rd_EX == rs)
                sel = 2'b01;
            else if (hif.RegWr_MEM && hif.Rd_MEM == rs)
                sel = 2'b10;
            else if (hif.RegWr_WB && hif.Rd_WB == rs)
                sel = 2'b11;
        end
        return sel;
    endfunction

    assign load_use = hif.MemRd_EX && hif.RegWr_EX
                   && (hif.Rd_EX != 5'd0)
                   && ((hif.UsesRs_ID && hif.Rd_EX == hif.Rs_ID)
                    || (hif.UsesRt_ID && hif.Rd_EX == hif.Rt_ID));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= 2'd0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (hif.halt_req && !load_use && !hif.taken_ID) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd3;
                end
            end
            DRAIN: begin
                if (!hif.halt_req) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end else if (load_use) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == 2'd0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            HALTED: begin
                if (!hif.halt_req)
                    state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
        halt_ack_d = (state_d == HALTED);
    end

    always_comb begin
        stall      = 1'b0;
        disable_IR = 1'b0;
        kill       = 1'b0;
        disable_PC = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        // Reset fills the IF/ID and ID/EX buffers with NOPs.
        if (reset) begin
            stall      = 1'b1;
            kill       = 1'b1;
            disable_PC = 1'b1;
        end else begin
            fwd_a = fwd_sel(hif.Rs_ID);
            fwd_b = fwd_sel(hif.Rt_ID);
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        stall      = 1'b1;
                        disable_IR = 1'b1;
                        disable_PC = 1'b1;
                    end else if (hif.taken_ID) begin
                        kill = 1'b1;
                    end
                end
                DRAIN: begin
                    if (load_use) begin
                        stall      = 1'b1;
                        disable_IR = 1'b1;
                        disable_PC = 1'b1;
                    end else begin
                        kill       = 1'b1;
                        disable_PC = !hif.taken_ID;
                    end
                end
                HALTED: begin
                    stall      = 1'b1;
                    kill       = 1'b1;
                    disable_PC = 1'b1;
                end
                default: begin
                    stall      = 1'b1;
                    kill       = 1'b1;
                    disable_PC = 1'b1;
                end
            endcase
        end
    end

    assign hif.stall      = stall;
    assign hif.disable_IR = disable_IR;
    assign hif.kill       = kill;
    assign hif.disable_PC = disable_PC;
    assign hif.FwdA       = fwd_a;
    assign hif.FwdB       = fwd_b;
    assign hif.halt_ack   = halt_ack_q;

`ifdef HAZ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] kill_cnt_q, kill_cnt_d;
    logic        lu_stall_ev, br_kill_ev;

    assign lu_stall_ev = load_use && (state_q != HALTED);
    assign br_kill_ev  = (state_q == RUN) && hif.taken_ID && !load_use;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (lu_stall_ev && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (br_kill_ev && kill_cnt_q != 16'hFFFF)
            kill_cnt_d = kill_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            kill_cnt_q  <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
    assign hif.kill_cnt  = kill_cnt_q;
`else
    assign hif.stall_cnt = 16'd0;
    assign hif.kill_cnt  = 16'd0;
`endif

endmodule
